dma_transfer_splitter_mc: RTL and testbench
===========================================

// Module: dma_transfer_splitter_mc
// PURPOSE
//  Multi-channel, parametrised successor of our single-channel DMA transfer splitter.
//  Accepts up to NUM_CHAN independent host<->device transfer descriptors and splits each into
//  PCIe-legal chunks: MPS for writes, MRRS for reads, optional 4 KB host-boundary cut.
//  Chunks from active channels go round-robin to one downstream DMA engine via a pending/done handshake.
//  Sits between the register/descriptor front-end and the TLP request generator.
// PARAMETERS
//  NUM_CHAN  4   number of descriptor channels (1..16)
//  ADDR_W    32  host/device address width
//  SIZE_W    32  transfer byte-count width
//  CH_W      $clog2(NUM_CHAN) (min 1)  channel index width, derived
// PORTS
//  i_clk                      in   1               clock
//  i_rst_n                    in   1               asynchronous active-low reset
//  pcie_dcommand              in   16              PCIe Device Control; [7:5]=MPS, [14:12]=MRRS
//  conf_valid                 in   NUM_CHAN        per-channel descriptor valid
//  conf_ready                 out  NUM_CHAN        per-channel descriptor accept (channel idle)
//  conf_start_address_host    in   NUM_CHAN*ADDR_W packed per-channel host start address
//  conf_start_address_device  in   NUM_CHAN*ADDR_W packed per-channel device start address
//  conf_size                  in   NUM_CHAN*SIZE_W packed per-channel byte count
//  conf_dir_write             in   NUM_CHAN        1 = device->host write, 0 = read
//  conf_transaction_done      out  NUM_CHAN        1-cycle pulse, descriptor fully transferred
//  dma_pending                out  1               chunk request valid, held until dma_done
//  dma_done                   in   1               downstream completion of current chunk
//  dma_address_host           out  ADDR_W          chunk host address
//  dma_address_device         out  ADDR_W          chunk device address
//  dma_size                   out  SIZE_W          chunk byte count (>0 while pending)
//  dma_dir_write              out  1               chunk direction
//  dma_chan                   out  CH_W            channel owning the chunk
// BEHAVIOUR
//  - Reset (async assert, sync release): all contexts idle, conf_ready=all 1s, conf_transaction_done=0,
//    dma_pending=0, dma_* outputs=0, RR pointer=0, MPS/MRRS codes=000.
//  - pcie_dcommand registered every cycle; MPS 000..011 -> 128..1024 B, 100..111 -> 128 B;
//    MRRS 000..101 -> 128..4096 B, 110/111 -> 128 B.
//  - conf_ready[c] = ~active[c]. Accept on conf_valid[c]&conf_ready[c]: context latches addr/size/dir,
//    active[c]=1 next cycle. Size 0: not activated; conf_transaction_done[c] pulses next cycle, no chunk issued.
//  - FSM ARB: if any channel active, RR-pick first active at/after pointer; register chunk =
//    min(remaining, max_bytes(dir), bytes_to_4K) into dma_* outputs; dma_chan=c; -> ISSUE.
//  - ISSUE: dma_pending=1, dma_* stable. On dma_done: context addr += chunk, remaining -= chunk,
//    pointer=c+1 (mod NUM_CHAN), -> ARB, dma_pending=0 next cycle. If remaining becomes 0:
//    active[c]=0, conf_transaction_done[c] pulses next cycle, conf_ready[c]=1 next cycle.
//  - Min gap between chunks: 1 idle cycle (ARB). First dma_pending: 2 cycles after accept.
//  - dma_done outside ISSUE ignored. MPS/MRRS changes apply at next ARB only, never to a pending chunk.
//  - Accepts on other channels proceed independently during ISSUE; active channel cannot be re-armed.
//  - Addresses wrap mod 2^ADDR_W; no overflow check. Async reset mid-transfer discards all contexts silently.
// CONFIGURATION
//  DMA_SPLIT_BOUNDARY_4K_EN defined: chunk also limited to 4096 - host_addr[11:0], so no chunk
//    crosses a 4 KB host boundary.
//  Not defined: chunk = min(remaining, max_bytes(dir)) only.
// STRUCTURE
//  Package dma_split_pkg: FSM state enum {ARB, ISSUE}; MPS/MRRS decode functions; BOUNDARY_BYTES=4096.
//  Sub-module dma_split_rr_arbiter: NUM_CHAN request vector + pointer -> one-hot grant + index.
// TESTING
//  1 ch0 read 300 B @host 0x1000, MRRS=000 -> chunks 128,128,44 at 0x1000/0x1080/0x1100; done[0] after 3rd dma_done.
//  2 ch1 write 256 B @host 0x0FC0, MPS=001, macro on -> chunks 64 then 192; macro off -> single 256.
//  3 ch0,ch2 both 256 B read, MRRS=000 -> dma_chan 0,2,0,2; done[0] before done[2].
//  4 ch3 size 0 -> no dma_pending, done[3] pulse 1 cycle after accept, conf_ready[3] stays 1.
//  5 MRRS code 111, read 200 B -> chunks 128,72; MPS code 101, write 200 B -> chunks 128,72.
//  6 i_rst_n low during ISSUE -> dma_pending=0 immediately, conf_ready all 1s, no done pulse.

Source files
------------

// File: rtl/dma_split_pkg.sv
// Shared types and PCIe size decoding for the multi-channel DMA transfer splitter.
// The optional 4 KB host-boundary cut in the top is enabled by DMA_SPLIT_BOUNDARY_4K_EN.
package dma_split_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        ISSUE = 1'b1
    } dma_split_state_e;

    localparam int BOUNDARY_BYTES = 4096;
    localparam int LIMIT_W        = 13;

    // MPS: 000..011 -> 128..1024 B, reserved codes fall back to 128 B
    function automatic logic [LIMIT_W-1:0] mps_bytes(input logic [2:0] code);
        return code[2] ? LIMIT_W'(128) : (LIMIT_W'(128) << code[1:0]);
    endfunction

    // MRRS: 000..101 -> 128..4096 B, reserved codes fall back to 128 B
    function automatic logic [LIMIT_W-1:0] mrrs_bytes(input logic [2:0] code);
        return (code[2] && code[1]) ? LIMIT_W'(128) : (LIMIT_W'(128) << code);
    endfunction

endpackage

// File: rtl/dma_split_rr_arbiter.sv
// Round-robin picker: first requesting channel at or after the pointer.
module dma_split_rr_arbiter #(
    parameter  int NUM_CHAN = 4,
    localparam int CH_W     = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
    input  logic [NUM_CHAN-1:0] req,
    input  logic [CH_W-1:0]     ptr,
    output logic [NUM_CHAN-1:0] grant,
    output logic [CH_W-1:0]     grant_idx,
    output logic                grant_valid
);

    always_comb begin
        int cand;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            cand = (int'(ptr) + i) % NUM_CHAN;
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = CH_W'(cand);
            end
        end
    end

endmodule

// File: rtl/dma_transfer_splitter_mc.sv
// Multi-channel DMA transfer splitter: per-channel descriptors cut into MPS/MRRS-sized chunks,
// served round-robin to one DMA engine. Define DMA_SPLIT_BOUNDARY_4K_EN to also cut at 4 KB host boundaries.
module dma_transfer_splitter_mc
    import dma_split_pkg::*;
#(
    parameter  int NUM_CHAN = 4,
    parameter  int ADDR_W   = 32,
    parameter  int SIZE_W   = 32,
    localparam int CH_W     = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [15:0]                pcie_dcommand,
    input  logic [NUM_CHAN-1:0]        conf_valid,
    output logic [NUM_CHAN-1:0]        conf_ready,
    input  logic [NUM_CHAN*ADDR_W-1:0] conf_start_address_host,
    input  logic [NUM_CHAN*ADDR_W-1:0] conf_start_address_device,
    input  logic [NUM_CHAN*SIZE_W-1:0] conf_size,
    input  logic [NUM_CHAN-1:0]        conf_dir_write,
    output logic [NUM_CHAN-1:0]        conf_transaction_done,
    output logic                       dma_pending,
    input  logic                       dma_done,
    output logic [ADDR_W-1:0]          dma_address_host,
    output logic [ADDR_W-1:0]          dma_address_device,
    output logic [SIZE_W-1:0]          dma_size,
    output logic                       dma_dir_write,
    output logic [CH_W-1:0]            dma_chan,
    output dma_split_state_e           dbg_state
);

    dma_split_state_e    state_q, state_d;
    logic [2:0]          mps_q, mrrs_q;
    logic [NUM_CHAN-1:0] active_q, done_q, dir_q;
    logic [ADDR_W-1:0]   host_q [NUM_CHAN];
    logic [ADDR_W-1:0]   dev_q  [NUM_CHAN];
    logic [SIZE_W-1:0]   rem_q  [NUM_CHAN];
    logic [CH_W-1:0]     ptr_q;

    logic [NUM_CHAN-1:0] arb_grant;
    logic [CH_W-1:0]     arb_idx;
    logic                arb_valid;
    logic                sel_dir;
    logic [LIMIT_W-1:0]  dir_limit;
    logic [SIZE_W-1:0]   chunk;
    logic                issue_load, chunk_done;
    logic                unused_dcmd;

    assign unused_dcmd = ^{pcie_dcommand[15], pcie_dcommand[11:8], pcie_dcommand[4:0]};

    dma_split_rr_arbiter #(.NUM_CHAN(NUM_CHAN)) u_arb (
        .req         (active_q),
        .ptr         (ptr_q),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    assign sel_dir   = |(arb_grant & dir_q);
    assign dir_limit = sel_dir ? mps_bytes(mps_q) : mrrs_bytes(mrrs_q);

    always_comb begin
`ifdef DMA_SPLIT_BOUNDARY_4K_EN
        logic [LIMIT_W-1:0] to_boundary;
        to_boundary = LIMIT_W'(BOUNDARY_BYTES) - {1'b0, host_q[arb_idx][11:0]};
`endif
        chunk = rem_q[arb_idx];
        if (SIZE_W'(dir_limit) < chunk) chunk = SIZE_W'(dir_limit);
`ifdef DMA_SPLIT_BOUNDARY_4K_EN
        if (SIZE_W'(to_boundary) < chunk) chunk = SIZE_W'(to_boundary);
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ARB;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (arb_valid) state_d = ISSUE;
            ISSUE:   if (dma_done)  state_d = ARB;
            default: state_d = ARB;
        endcase
    end

    assign issue_load = (state_q == ARB) && arb_valid;
    assign chunk_done = (state_q == ISSUE) && dma_done;

    // Contexts and the chunk registers share one process; an active channel never accepts,
    // so accept and completion updates never target the same context in one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mps_q              <= '0;
            mrrs_q             <= '0;
            active_q           <= '0;
            done_q             <= '0;
            dir_q              <= '0;
            ptr_q              <= '0;
            dma_address_host   <= '0;
            dma_address_device <= '0;
            dma_size           <= '0;
            dma_dir_write      <= 1'b0;
            dma_chan           <= '0;
            for (int c = 0; c < NUM_CHAN; c++) begin
                host_q[c] <= '0;
                dev_q[c]  <= '0;
                rem_q[c]  <= '0;
            end
        end else begin
            mps_q  <= pcie_dcommand[7:5];
            mrrs_q <= pcie_dcommand[14:12];
            done_q <= '0;
            for (int c = 0; c < NUM_CHAN; c++) begin
                if (conf_valid[c] && !active_q[c]) begin
                    host_q[c] <= conf_start_address_host[c*ADDR_W +: ADDR_W];
                    dev_q[c]  <= conf_start_address_device[c*ADDR_W +: ADDR_W];
                    rem_q[c]  <= conf_size[c*SIZE_W +: SIZE_W];
                    dir_q[c]  <= conf_dir_write[c];
                    if (conf_size[c*SIZE_W +: SIZE_W] == '0) done_q[c]   <= 1'b1;
                    else                                     active_q[c] <= 1'b1;
                end
            end
            if (issue_load) begin
                dma_address_host   <= host_q[arb_idx];
                dma_address_device <= dev_q[arb_idx];
                dma_size           <= chunk;
                dma_dir_write      <= sel_dir;
                dma_chan           <= arb_idx;
            end
            if (chunk_done) begin
                host_q[dma_chan] <= dma_address_host + ADDR_W'(dma_size);
                dev_q[dma_chan]  <= dma_address_device + ADDR_W'(dma_size);
                rem_q[dma_chan]  <= rem_q[dma_chan] - dma_size;
                ptr_q            <= (dma_chan == CH_W'(NUM_CHAN - 1)) ? '0 : dma_chan + CH_W'(1);
                if (rem_q[dma_chan] == dma_size) begin
                    active_q[dma_chan] <= 1'b0;
                    done_q[dma_chan]   <= 1'b1;
                end
            end
        end
    end

    assign conf_ready            = ~active_q;
    assign conf_transaction_done = done_q;
    assign dma_pending           = (state_q == ISSUE);
    assign dbg_state             = state_q;

endmodule

// File: tb/tb_dma_transfer_splitter_mc.sv
// Bench for dma_transfer_splitter_mc: table vectors, hand-written corner sequences and random descriptors.
module tb_dma_transfer_splitter_mc;
    import dma_split_pkg::*;

    localparam int NC = 4;
    localparam int AW = 32;
    localparam int SW = 32;
    localparam int CW = 2 + 1 + AW + AW + SW;

    logic              i_clk, i_rst_n;
    logic [15:0]       pcie_dcommand;
    logic [NC-1:0]     conf_valid, conf_ready, conf_dir_write, conf_transaction_done;
    logic [NC*AW-1:0]  conf_start_address_host, conf_start_address_device;
    logic [NC*SW-1:0]  conf_size;
    logic              dma_pending, dma_done, dma_dir_write;
    logic [AW-1:0]     dma_address_host, dma_address_device;
    logic [SW-1:0]     dma_size;
    logic [1:0]        dma_chan;
    dma_split_state_e  dbg_state;

    dma_transfer_splitter_mc #(.NUM_CHAN(NC), .ADDR_W(AW), .SIZE_W(SW)) dut (
        .i_clk                     (i_clk),
        .i_rst_n                   (i_rst_n),
        .pcie_dcommand             (pcie_dcommand),
        .conf_valid                (conf_valid),
        .conf_ready                (conf_ready),
        .conf_start_address_host   (conf_start_address_host),
        .conf_start_address_device (conf_start_address_device),
        .conf_size                 (conf_size),
        .conf_dir_write            (conf_dir_write),
        .conf_transaction_done     (conf_transaction_done),
        .dma_pending               (dma_pending),
        .dma_done                  (dma_done),
        .dma_address_host          (dma_address_host),
        .dma_address_device        (dma_address_device),
        .dma_size                  (dma_size),
        .dma_dir_write             (dma_dir_write),
        .dma_chan                  (dma_chan),
        .dbg_state                 (dbg_state)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n_total = 0;
    int n_pass  = 0;
    logic [2:0] mps_code, mrrs_code;
    logic [CW-1:0] exp_q[$];

    typedef struct {
        int          ch;
        bit          wr;
        logic [31:0] host;
        logic [31:0] dev;
        logic [31:0] size;
        logic [2:0]  mps;
        logic [2:0]  mrrs;
        int          n;
        logic [31:0] s0, s1, s2;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // reference model: chunk list from the size rules with plain arithmetic
    function automatic void model_push(input int ch, input bit wr, input logic [31:0] host,
                                       input logic [31:0] dev, input logic [31:0] size);
        longint rem, lim, c, to4k;
        logic [31:0] h, d;
        rem = longint'(size);
        h = host;
        d = dev;
        lim = wr ? ((mps_code < 4) ? (128 << mps_code) : 128)
                 : ((mrrs_code < 6) ? (128 << mrrs_code) : 128);
        while (rem > 0) begin
            c = (rem < lim) ? rem : lim;
`ifdef DMA_SPLIT_BOUNDARY_4K_EN
            to4k = 4096 - longint'(h[11:0]);
            if (to4k < c) c = to4k;
`else
            to4k = 0;
`endif
            exp_q.push_back({2'(ch), wr, h, d, c[31:0]});
            h = h + c[31:0];
            d = d + c[31:0];
            rem = rem - c;
        end
    endfunction

    // driver tasks
    task automatic set_dcmd(input logic [2:0] mps, input logic [2:0] mrrs);
        logic [15:0] v;
        v = 16'($urandom);
        v[7:5] = mps;
        v[14:12] = mrrs;
        pcie_dcommand = v;
        mps_code = mps;
        mrrs_code = mrrs;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic drive(input int ch, input bit wr, input logic [31:0] host,
                         input logic [31:0] dev, input logic [31:0] size);
        conf_valid[ch] = 1'b1;
        conf_dir_write[ch] = wr;
        conf_start_address_host[ch*AW +: AW] = host;
        conf_start_address_device[ch*AW +: AW] = dev;
        conf_size[ch*SW +: SW] = size;
    endtask

    task automatic commit();
        @(posedge i_clk);
        @(negedge i_clk);
        conf_valid = '0;
    endtask

    // wait for a chunk, hold it a random time, then complete it; returns at the negedge after dma_done
    task automatic serve(input string name, output logic got, output logic [CW-1:0] c, output int waited);
        waited = 0;
        while (!dma_pending && waited < 50) begin
            @(negedge i_clk);
            waited++;
        end
        got = dma_pending;
        c = {dma_chan, dma_dir_write, dma_address_host, dma_address_device, dma_size};
        if (got) begin
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
            chk({name, " stable"}, {dma_pending, dma_chan, dma_dir_write, dma_address_host,
                                    dma_address_device, dma_size}, {1'b1, c});
            dma_done = 1'b1;
            @(negedge i_clk);
            dma_done = 1'b0;
        end
    endtask

    task automatic run_desc(input string name, input int ch, input bit wr, input logic [31:0] host,
                            input logic [31:0] dev, input logic [31:0] size, input int tn,
                            input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
        logic [CW-1:0] e, c;
        logic got;
        int w, k;
        logic [31:0] ts[3];
        ts[0] = s0; ts[1] = s1; ts[2] = s2;
        exp_q.delete();
        model_push(ch, wr, host, dev, size);
        drive(ch, wr, host, dev, size);
        commit();
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            serve(name, got, c, w);
            chk({name, " chunk"}, c, e);
            if (k < tn && k < 3) chk({name, " table size"}, c[SW-1:0], ts[k]);
            chk({name, " latency"}, w, 1);
            chk({name, " done"}, conf_transaction_done, (exp_q.size() == 0) ? 4'(1 << ch) : 4'd0);
            chk({name, " gap"}, dma_pending, 1'b0);
            k++;
        end
        @(negedge i_clk);
        chk({name, " no extra chunk"}, dma_pending, 1'b0);
        chk({name, " done 1 cycle"}, conf_transaction_done, 4'd0);
        chk({name, " ready"}, conf_ready, 4'hF);
    endtask

    function automatic vec_t mk(input int ch, input bit wr, input logic [31:0] host, input logic [31:0] dev,
                                input logic [31:0] size, input logic [2:0] mps, input logic [2:0] mrrs,
                                input int n, input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
        vec_t v;
        v.ch = ch; v.wr = wr; v.host = host; v.dev = dev; v.size = size;
        v.mps = mps; v.mrrs = mrrs; v.n = n; v.s0 = s0; v.s1 = s1; v.s2 = s2;
        return v;
    endfunction

    initial begin
        logic [CW-1:0] e, c;
        logic got;
        int w;
        logic [3:0] exp_done;

        i_rst_n = 1'b0;
        pcie_dcommand = '0;
        mps_code = '0;
        mrrs_code = '0;
        conf_valid = '0;
        conf_dir_write = '0;
        conf_start_address_host = '0;
        conf_start_address_device = '0;
        conf_size = '0;
        dma_done = 1'b0;

        tbl.push_back(mk(0, 0, 32'h0000_1000, 32'h0002_0000, 300, 0, 0, 3, 128, 128, 44));
`ifdef DMA_SPLIT_BOUNDARY_4K_EN
        tbl.push_back(mk(1, 1, 32'h0000_0FC0, 32'h0000_0000, 256, 1, 0, 2, 64, 192, 0));
        tbl.push_back(mk(2, 1, 32'hFFFF_FF00, 32'h0000_5000, 600, 2, 0, 2, 256, 344, 0));
`else
        tbl.push_back(mk(1, 1, 32'h0000_0FC0, 32'h0000_0000, 256, 1, 0, 1, 256, 0, 0));
        tbl.push_back(mk(2, 1, 32'hFFFF_FF00, 32'h0000_5000, 600, 2, 0, 2, 512, 88, 0));
`endif
        tbl.push_back(mk(2, 0, 32'h0000_3000, 32'h0000_0040, 200, 0, 7, 2, 128, 72, 0));
        tbl.push_back(mk(3, 1, 32'h0000_6000, 32'h0000_0080, 200, 5, 0, 2, 128, 72, 0));
        tbl.push_back(mk(1, 1, 32'h0001_0000, 32'h0000_0000, 1024, 3, 0, 1, 1024, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0002_0000, 32'h0000_0000, 4096, 0, 5, 1, 4096, 0, 0));

        // reset state
        repeat (3) @(negedge i_clk);
        chk("reset ready", conf_ready, 4'hF);
        chk("reset done", conf_transaction_done, 4'd0);
        chk("reset pending", dma_pending, 1'b0);
        chk("reset outputs", {dma_address_host, dma_address_device, dma_size, dma_dir_write, dma_chan}, '0);
        chk("reset state", dbg_state, ARB);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // stray dma_done outside ISSUE must be ignored
        dma_done = 1'b1;
        @(negedge i_clk);
        dma_done = 1'b0;
        chk("stray done", {dma_pending, conf_transaction_done, conf_ready}, {1'b0, 4'd0, 4'hF});

        foreach (tbl[i]) begin
            set_dcmd(tbl[i].mps, tbl[i].mrrs);
            run_desc($sformatf("vec%0d", i), tbl[i].ch, tbl[i].wr, tbl[i].host, tbl[i].dev,
                     tbl[i].size, tbl[i].n, tbl[i].s0, tbl[i].s1, tbl[i].s2);
        end

        // zero-size descriptor
        drive(3, 0, 32'h0000_7000, 32'h0, 32'd0);
        commit();
        chk("zero done pulse", conf_transaction_done, 4'b1000);
        chk("zero ready", conf_ready, 4'hF);
        chk("zero pending", dma_pending, 1'b0);
        @(negedge i_clk);
        chk("zero done clear", conf_transaction_done, 4'd0);
        repeat (2) @(negedge i_clk);
        chk("zero no chunk", dma_pending, 1'b0);

        // random single-channel descriptors
        for (int r = 0; r < 15; r++) begin
            set_dcmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            run_desc($sformatf("rand%0d", r), $urandom_range(0, NC - 1), 1'($urandom),
                     $urandom, $urandom, $urandom_range(1, 2500), 0, 0, 0, 0);
        end

        // reset while a chunk is pending
        set_dcmd(0, 0);
        drive(1, 0, 32'h0000_1000, 32'h0, 32'd300);
        commit();
        w = 0;
        while (!dma_pending && w < 50) begin
            @(negedge i_clk);
            w++;
        end
        chk("rst pre pending", dbg_state, ISSUE);
        i_rst_n = 1'b0;
        #1;
        chk("rst pending", dma_pending, 1'b0);
        chk("rst ready", conf_ready, 4'hF);
        chk("rst done", conf_transaction_done, 4'd0);
        chk("rst size", dma_size, '0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("rst discarded", {dma_pending, conf_transaction_done, conf_ready}, {1'b0, 4'd0, 4'hF});

        // two channels interleaved round-robin; re-arm of an active channel is ignored
        exp_q.delete();
        exp_q.push_back({2'd0, 1'b0, 32'h0000_4000, 32'h0000_0100, 32'd128});
        exp_q.push_back({2'd2, 1'b0, 32'h0000_8000, 32'h0000_0900, 32'd128});
        exp_q.push_back({2'd0, 1'b0, 32'h0000_4080, 32'h0000_0180, 32'd128});
        exp_q.push_back({2'd2, 1'b0, 32'h0000_8080, 32'h0000_0980, 32'd128});
        drive(0, 0, 32'h0000_4000, 32'h0000_0100, 32'd256);
        drive(2, 0, 32'h0000_8000, 32'h0000_0900, 32'd256);
        commit();
        chk("rr ready", conf_ready, 4'b1010);
        drive(0, 1, 32'hDEAD_0000, 32'h0, 32'd999);
        commit();
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            serve($sformatf("rr%0d", k), got, c, w);
            chk($sformatf("rr%0d chunk", k), c, e);
            exp_done = (k == 2) ? 4'b0001 : ((k == 3) ? 4'b0100 : 4'b0000);
            chk($sformatf("rr%0d done", k), conf_transaction_done, exp_done);
        end
        @(negedge i_clk);
        chk("rr end", {dma_pending, conf_ready}, {1'b0, 4'hF});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
